// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the ALU command path.
// Receiver FSM states and default frame geometry.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_frame_sync_2ff.sv
// Double-flop synchronizer with a parameterized reset value.
// Used to bring the asynchronous serial line into the i_clk domain.
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// 16x oversampled UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to add a parity bit (8E1/8O1).
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = DEF_DATA_BITS,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int SB_TICKS   = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_tick,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_rx_done,
   output logic                 o_frame_err,
   output logic                 o_parity_err
);

   localparam int S_W = $clog2(OVERSAMPLE);
   localparam int N_W = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
   localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
   localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

   rx_state_t            state_q, state_d;
   logic [S_W-1:0]       s_q, s_d;
   logic [N_W-1:0]       n_q, n_d;
   logic [DATA_BITS-1:0] b_q, b_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_q, par_d;
   logic                 done_q, done_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 rx_s;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .d       (i_rx),
      .q       (rx_s)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         par_q   <= 1'b0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         data_q  <= data_d;
         par_q   <= par_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      data_d  = data_q;
      par_d   = par_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Start edge is taken immediately, not on a tick
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (i_tick) begin
               if (s_q == S_HALF) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         DATA: begin
            if (i_tick) begin
               if (s_q == S_LAST) begin
                  s_d = '0;
                  b_d = {rx_s, b_q[DATA_BITS-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = PAR_EN ? PARITY : STOP;
                  end else begin
                     n_d = n_q + N_W'(1);
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         PARITY: begin
            if (i_tick) begin
               if (s_q == S_LAST) begin
                  par_d   = rx_s;
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         STOP: begin
            if (i_tick) begin
               if (s_q == S_STOP) begin
                  if (rx_s) begin
                     data_d  = b_q;
                     done_d  = 1'b1;
                     perr_d  = PAR_EN &&
                               (par_q != (^b_q ^ PARITY_ODD));
                     state_d = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = BREAK;
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         BREAK: begin
            // Hold off until the line is released high
            if (i_tick && rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_data       = data_q;
   assign o_rx_done    = done_q;
   assign o_frame_err  = ferr_q;
   assign o_parity_err = perr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: tick every 4 clocks, 64 clocks per bit.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_frame;

`ifdef UART_RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int BIT_CLKS = 64;
   localparam int EXP_LAT  = PAR ? 672 : 608;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_tick;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_rx_done;
   logic       o_frame_err;
   logic       o_parity_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;
   int both_cnt = 0;
   int lone_perr = 0;
   int last_done = 0;
   int start_cyc = 0;
   logic [7:0] done_q[$];

   typedef struct {
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   uart_rx_frame dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_tick       (i_tick),
      .i_rx         (i_rx),
      .o_data       (o_data),
      .o_rx_done    (o_rx_done),
      .o_frame_err  (o_frame_err),
      .o_parity_err (o_parity_err)
   );

   initial begin
      int tcnt;
      tcnt = 0;
      i_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         i_tick = (tcnt == 3);
         tcnt = (tcnt + 1) % 4;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (o_rx_done) begin
         done_cnt++;
         done_q.push_back(o_data);
         last_done = cyc;
      end
      if (o_frame_err) ferr_cnt++;
      if (o_parity_err) perr_cnt++;
      if (o_rx_done && o_frame_err) both_cnt++;
      if (o_parity_err && !o_rx_done) lone_perr++;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bit_time(input logic v);
      i_rx = v;
      clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input logic pbit);
      start_cyc = cyc;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      if (PAR) bit_time(pbit);
      bit_time(stop);
   endtask

   task automatic send_ok(input logic [7:0] d);
      send_frame(d, 1'b1, ^d);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      int f0;
      int p0;
      int lat;
      vecs[0] = '{8'hA5, 8'hA5};
      vecs[1] = '{8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF};
      vecs[3] = '{8'h80, 8'h80};
      vecs[4] = '{8'h01, 8'h01};

      i_reset = 1'b1;
      i_rx = 1'b1;
      clks(4);
      @(negedge clk);
      check("reset_data", o_data, 8'h00);
      check("reset_strobes",
            {o_rx_done, o_frame_err, o_parity_err}, 3'b000);
      @(posedge clk);
      #1;
      i_reset = 1'b0;
      clks(BIT_CLKS);

      for (int i = 0; i < 5; i++) begin
         d0 = done_cnt;
         f0 = ferr_cnt;
         send_ok(vecs[i].d);
         clks(8);
         check($sformatf("vec%0d_data", i), o_data, vecs[i].exp);
         check($sformatf("vec%0d_done", i), done_cnt - d0, 1);
         check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, 0);
         lat = last_done - start_cyc;
         checks++;
         if (lat < EXP_LAT - 10 || lat > EXP_LAT + 10) begin
            errors++;
            $display("FAIL vec%0d_latency: got %0d want %0d+-10",
                     i, lat, EXP_LAT);
         end
      end

      // start glitch: 4 ticks low
      d0 = done_cnt;
      f0 = ferr_cnt;
      i_rx = 1'b0;
      clks(16);
      i_rx = 1'b1;
      clks(3 * BIT_CLKS);
      check("glitch_done", done_cnt - d0, 0);
      check("glitch_ferr", ferr_cnt - f0, 0);
      check("glitch_data", o_data, vecs[4].exp);

      // framing error, line held low
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, ^8'h3C);
      i_rx = 1'b0;
      clks(3 * BIT_CLKS);
      check("break_ferr", ferr_cnt - f0, 1);
      check("break_done", done_cnt - d0, 0);
      check("break_data", o_data, vecs[4].exp);
      check("break_both", both_cnt, 0);
      i_rx = 1'b1;
      clks(BIT_CLKS);
      d0 = done_cnt;
      send_ok(8'h11);
      clks(8);
      check("after_break_data", o_data, 8'h11);
      check("after_break_done", done_cnt - d0, 1);

      // back-to-back
      done_q.delete();
      send_ok(8'h01);
      send_ok(8'hFF);
      send_ok(8'h20);
      clks(8);
      check("b2b_count", done_q.size(), 3);
      if (done_q.size() == 3) begin
         check("b2b_0", done_q[0], 8'h01);
         check("b2b_1", done_q[1], 8'hFF);
         check("b2b_2", done_q[2], 8'h20);
      end

      // reset during data bit 4 of 0x77
      d0 = done_cnt;
      bit_time(1'b0);
      for (int i = 0; i < 4; i++) bit_time(1'b1 & (8'h77 >> i));
      i_rx = 1'b1;
      clks(32);
      i_reset = 1'b1;
      clks(1);
      i_reset = 1'b0;
      clks(2 * BIT_CLKS);
      check("rst_mid_done", done_cnt - d0, 0);
      check("rst_mid_data", o_data, 8'h00);
      d0 = done_cnt;
      send_ok(8'h42);
      clks(8);
      check("after_rst_data", o_data, 8'h42);
      check("after_rst_done", done_cnt - d0, 1);

      if (PAR) begin
         d0 = done_cnt;
         p0 = perr_cnt;
         send_frame(8'h03, 1'b1, 1'b1);
         clks(8);
         check("par_bad_done", done_cnt - d0, 1);
         check("par_bad_data", o_data, 8'h03);
         check("par_bad_perr", perr_cnt - p0, 1);
         d0 = done_cnt;
         p0 = perr_cnt;
         send_frame(8'h03, 1'b1, 1'b0);
         clks(8);
         check("par_ok_done", done_cnt - d0, 1);
         check("par_ok_perr", perr_cnt - p0, 0);
      end

      check("perr_total", perr_cnt, PAR ? 1 : 0);
      check("perr_alone", lone_perr, 0);
      check("done_ferr_both", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Serial UART receiver for the ALU command path: it samples the asynchronous `i_rx` line with 16x oversampling and recovers 8N1 frames (or 8E1/8O1 when parity is compiled in). It delivers each byte with a one-cycle strobe. It sits directly upstream of the operand-assembly interface:
- `o_data` drives that block's byte input.
- `o_rx_done` drives its receive-done flag.
- Three frames make one ALU command: A, B, then opcode.

## Interface
- `DATA_BITS`, 8, data bits per frame, shifted in LSB first.
- `OVERSAMPLE`, 16, ticks per bit period.
- `SB_TICKS`, 16, ticks from the last sample point to the stop-bit sample point.
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous, active-high reset, sampled on `i_clk` rising edge.
- `i_tick`  in  1  one-`i_clk` pulse at `OVERSAMPLE` × baud, from the shared baud generator.
- `i_rx`  in  1  asynchronous serial line, idle high.
- `o_data`  out  `DATA_BITS`  last correctly framed byte.
- `o_rx_done`  out  1  one-cycle strobe when `o_data` is updated.
- `o_frame_err`  out  1  one-cycle strobe when the stop bit is sampled low.
- `o_parity_err`  out  1  one-cycle strobe, coincident with `o_rx_done`, on parity mismatch.

## Operation
- `i_rx` passes through a 2-FF synchronizer. All decisions use the synchronized value `rx_s`.
- Counters:
  - `s`: tick counter, width clog2(`OVERSAMPLE`).
  - `n`: bit counter, width clog2(`DATA_BITS`).
  - `b`: shift register.
- Counters advance only in cycles where `i_tick` = 1. In all other cycles state, `s` and `n` hold.
- IDLE: when `rx_s` = 0, go to START with `s` = 0. This transition does not wait for a tick.
- START: on each tick, `s`++. At `s` = `OVERSAMPLE`/2−1:
  - if `rx_s` = 0, go to DATA with `s` = 0 and `n` = 0;
  - otherwise it is a glitch: go to IDLE with no output activity.
- DATA: on each tick, `s`++. At `s` = `OVERSAMPLE`−1:
  - set `s` = 0 and `b` = {`rx_s`, `b`[`DATA_BITS`−1:1]};
  - if `n` = `DATA_BITS`−1, go to PARITY (macro defined) or STOP; otherwise `n`++.
- PARITY: at `s` = `OVERSAMPLE`−1, latch the parity bit, then go to STOP with `s` = 0.
- STOP: at `s` = `SB_TICKS`−1, sample `rx_s`:
  - 1: `o_data` ← `b`, pulse `o_rx_done`, and pulse `o_parity_err` if parity is enabled and mismatched. Go to IDLE.
  - 0: pulse `o_frame_err`. `o_data` is unchanged and `o_rx_done` is not pulsed. Go to BREAK.
- BREAK: stay until `rx_s` = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Back-to-back frames: reaching IDLE at the mid-stop sample point leaves half a bit period to detect the next start edge.

## Timing
- Reset values:
  - state IDLE;
  - `s`, `n`, `b` = 0;
  - `o_data` = 0;
  - all strobes 0;
  - synchronizer flops = 1.
- Reset wins over a simultaneous `i_tick`.
- Reset mid-frame aborts the frame: no `o_rx_done`, `o_data` is cleared.
- Input latency: 2 `i_clk` cycles from `i_rx` to `rx_s`.
- `o_rx_done` and `o_frame_err` are registered and assert in the cycle after the tick that samples the stop bit. `o_rx_done` and `o_frame_err` are never high together.
- `o_data` is valid from the `o_rx_done` cycle and holds until the next successful frame.
- Strobes last exactly one `i_clk` cycle regardless of the tick rate.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present.
  - The frame has one parity bit after the data bits.
  - Expected parity is ^`b` XOR `PARITY_ODD`.
  - `o_parity_err` is driven as described in Operation. The byte is still delivered.
- Not defined:
  - No PARITY state; DATA goes directly to STOP.
  - `o_parity_err` is tied 0. The port remains, so integration is unchanged.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - default `OVERSAMPLE` and `DATA_BITS` constants.
- The baud tick generator is shared with the TX path and is not part of this block.
- One sub-module, `sync_2ff`: a parameterized reset-value double-flop synchronizer instantiated for `i_rx`.

## Test plan
Bench setup: `i_tick` every 4 `i_clk` cycles, so one bit = 64 clocks.
- Frame 0xA5 (8N1): `o_data` = 0xA5 and exactly one `o_rx_done` pulse, about 2 clocks after the mid-stop tick. No `o_frame_err`.
- `i_rx` low for 4 ticks, then high (start glitch): return to IDLE, no strobes, `o_data` unchanged.
- Frame 0x3C with the stop bit driven 0 and the line held low for 3 bit times: one `o_frame_err` pulse, no `o_rx_done`, and no new frame until the line returns high. A subsequent frame 0x11 is then received correctly.
- Back-to-back frames 0x01, 0xFF, 0x20 with no idle gap: three `o_rx_done` pulses, with `o_data` sequence 0x01, 0xFF, 0x20.
- Reset asserted during DATA bit 4 of frame 0x77: no `o_rx_done`, `o_data` = 0. The next frame 0x42 is received correctly.
- With `UART_RX_PARITY_EN` and `PARITY_ODD` = 0: frame 0x03 with parity bit 1 gives `o_rx_done`, `o_data` = 0x03, and `o_parity_err` pulsed. The same frame with parity bit 0 gives no `o_parity_err`.
